// File: rtl/nibble_code_lock_pkg.sv
// Shared types and constants for the nibble code lock: state encoding,
// default key width and the timer width helper.
package nibble_code_lock_pkg;

  localparam int KEY_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  // Down-counter width large enough for the longer of the two windows, never below 1 bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/nibble_code_lock_if.sv
// Keypad-side handshake and status bundle of the code lock.
// master = code source / keypad, slave = lock.
interface nibble_code_lock_if
  import nibble_code_lock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
);
  logic             key_load;
  logic [KEY_W-1:0] key_in;
  logic             try_valid;
  logic [KEY_W-1:0] try_code;
  logic             ready;
  logic             unlocked;
  logic             alarm;
  logic [1:0]       fails;

  modport master (
    output key_load, key_in, try_valid, try_code,
    input  ready, unlocked, alarm, fails
  );

  modport slave (
    input  key_load, key_in, try_valid, try_code,
    output ready, unlocked, alarm, fails
  );
endinterface

// File: rtl/nibble_code_lock_eq.sv
// Gate-level equality: per-bit XNOR followed by an AND reduction tree.
module nibble_eq #(
  parameter int KEY_W = 4
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  output logic             eq
);
  logic [KEY_W-1:0] bit_eq;

  for (genvar i = 0; i < KEY_W; i++) begin : g_xnor
    assign bit_eq[i] = ~(a[i] ^ b[i]);
  end

  assign eq = &bit_eq;
endmodule

// File: rtl/nibble_code_lock.sv
// Code lock front-end: holds the key, checks trial codes, drives a timed unlock
// window or counts failures into a timed alarm lockout.
module nibble_code_lock
  import nibble_code_lock_pkg::*;
#(
  parameter int KEY_W          = KEY_W_DEF,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_code_lock_if.slave   bus
);
  localparam int TW = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  lock_state_t      state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [KEY_W-1:0] try_reg, try_nxt;
  logic [1:0]       fails, fails_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             eq;
  logic             fails_last;

  nibble_eq #(.KEY_W(KEY_W)) u_eq (
    .a  (try_reg),
    .b  (key_reg),
    .eq (eq)
  );

  // This failure is the one that reaches the lockout threshold.
  assign fails_last = ((32'(fails) + 32'd1) >= 32'(MAX_FAILS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      try_reg <= '0;
      fails   <= '0;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      try_reg <= try_nxt;
      fails   <= fails_nxt;
      timer   <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    try_nxt   = try_reg;
    fails_nxt = fails;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        // key_load has priority; a simultaneous trial is dropped.
        if (bus.key_load) begin
          key_nxt   = bus.key_in;
          fails_nxt = '0;
        end else if (bus.try_valid) begin
          try_nxt   = bus.try_code;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (eq) begin
          fails_nxt = '0;
          timer_nxt = TW'(UNLOCK_CYCLES - 1);
          state_nxt = OPEN;
        end else begin
          fails_nxt = fails + 2'd1;
          if (fails_last) begin
            timer_nxt = TW'(LOCKOUT_CYCLES - 1);
            state_nxt = LOCKOUT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OPEN: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - TW'(1);
      end
      LOCKOUT: begin
        if (timer == '0) begin
          fails_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready    = (state == IDLE);
  assign bus.unlocked = (state == OPEN);
  assign bus.alarm    = (state == LOCKOUT);
  assign bus.fails    = fails;
endmodule

// File: tb/tb_nibble_code_lock.sv
// Self-checking bench for nibble_code_lock: directed scenarios plus random
// key/trial traffic checked against a scenario-level model of the lock.
module tb_nibble_code_lock;
  localparam int UNL  = 8;
  localparam int LCK  = 16;
  localparam int MAXF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nibble_code_lock_if #(.KEY_W(4)) bus ();

  nibble_code_lock #(
    .KEY_W(4), .MAX_FAILS(MAXF), .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec = 0;
  int errs = 0;

  // Model: only the stored key and the consecutive-failure count.
  logic [3:0] m_key = 4'd0;
  int         m_fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.key_load  = 1'b0;
    bus.try_valid = 1'b0;
    bus.key_in    = 4'($urandom);
    bus.try_code  = 4'($urandom);
  endtask

  // One full trial from acceptance until the lock is back in IDLE.
  task automatic do_trial(input logic [3:0] code);
    bit hit;
    int waitc;
    waitc = 0;
    while (bus.ready !== 1'b1 && waitc < 64) begin
      step();
      waitc++;
    end
    vec++;
    if (bus.ready !== 1'b1) begin
      errs++;
      $display("FAIL trial_wait_ready: ready=%b required 1", bus.ready);
    end
    hit = (code == m_key);
    bus.try_code  = code;
    bus.try_valid = 1'b1;
    step();
    idle_inputs();
    vec++;
    if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b000 || bus.fails !== 2'(m_fails)) begin
      errs++;
      $display("FAIL check_cycle: rdy/unl/alm=%b fails=%0d required 000 fails=%0d",
               {bus.ready, bus.unlocked, bus.alarm}, bus.fails, m_fails);
    end
    if (hit) begin
      m_fails = 0;
      for (int i = 0; i < UNL; i++) begin
        step();
        vec++;
        if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b010 || bus.fails !== 2'd0) begin
          errs++;
          $display("FAIL open_window[%0d]: rdy/unl/alm=%b fails=%0d required 010 fails=0",
                   i, {bus.ready, bus.unlocked, bus.alarm}, bus.fails);
        end
      end
    end else begin
      m_fails++;
      if (m_fails == MAXF) begin
        for (int i = 0; i < LCK; i++) begin
          // Junk requests during the alarm must be ignored.
          bus.try_valid = 1'($urandom_range(0, 1));
          bus.try_code  = m_key;
          bus.key_load  = 1'($urandom_range(0, 1));
          bus.key_in    = 4'($urandom);
          step();
          vec++;
          if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b001 || bus.fails !== 2'(MAXF)) begin
            errs++;
            $display("FAIL lockout_window[%0d]: rdy/unl/alm=%b fails=%0d required 001 fails=%0d",
                     i, {bus.ready, bus.unlocked, bus.alarm}, bus.fails, MAXF);
          end
        end
        idle_inputs();
        m_fails = 0;
      end
    end
    step();
    vec++;
    if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b100 || bus.fails !== 2'(m_fails)) begin
      errs++;
      $display("FAIL back_to_idle: rdy/unl/alm=%b fails=%0d required 100 fails=%0d",
               {bus.ready, bus.unlocked, bus.alarm}, bus.fails, m_fails);
    end
  endtask

  task automatic load_key(input logic [3:0] k, input bit with_try);
    bus.key_load  = 1'b1;
    bus.key_in    = k;
    bus.try_valid = with_try;
    bus.try_code  = ~k;
    step();
    idle_inputs();
    m_key   = k;
    m_fails = 0;
    vec++;
    if (bus.ready !== 1'b1 || bus.fails !== 2'd0 || bus.unlocked !== 1'b0) begin
      errs++;
      $display("FAIL key_load: ready=%b fails=%0d unlocked=%b required 1/0/0",
               bus.ready, bus.fails, bus.unlocked);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    vec++;
    if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b100 || bus.fails !== 2'd0) begin
      errs++;
      $display("FAIL reset_state: rdy/unl/alm=%b fails=%0d required 100 fails=0",
               {bus.ready, bus.unlocked, bus.alarm}, bus.fails);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    vec++;
    if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b100) begin
      errs++;
      $display("FAIL idle_after_reset: rdy/unl/alm=%b required 100",
               {bus.ready, bus.unlocked, bus.alarm});
    end
    m_key = 4'd0;
    m_fails = 0;
    do_trial(4'b0000);
  endtask

  task automatic test_open();
    load_key(4'b0100, 1'b0);
    do_trial(4'b0100);
  endtask

  task automatic test_fail_then_open();
    load_key(4'b1011, 1'b0);
    do_trial(4'b1010);
    do_trial(4'b0101);
    do_trial(4'b1011);
  endtask

  task automatic test_lockout();
    load_key(4'b1000, 1'b0);
    do_trial(4'b0101);
    do_trial(4'b0101);
    do_trial(4'b0101);
    do_trial(4'b1000);
  endtask

  task automatic test_collision();
    load_key(4'b1110, 1'b1);
    step();
    vec++;
    if (bus.ready !== 1'b1 || bus.fails !== 2'd0) begin
      errs++;
      $display("FAIL collision_no_check: ready=%b fails=%0d required 1/0", bus.ready, bus.fails);
    end
    do_trial(4'b0001);
    do_trial(4'b1110);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.ready, bus.unlocked, bus.alarm} !== 3'b100 || bus.fails !== 2'd0) begin
      errs++;
      $display("FAIL async_reset_%s: rdy/unl/alm=%b fails=%0d required 100 fails=0",
               tag, {bus.ready, bus.unlocked, bus.alarm}, bus.fails);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_key = 4'd0;
    m_fails = 0;
    step();
  endtask

  task automatic test_async_reset();
    load_key(4'b0110, 1'b0);
    bus.try_code = 4'b0110;
    bus.try_valid = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    vec++;
    if (bus.unlocked !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset_open: unlocked=%b required 1", bus.unlocked);
    end
    reset_pulse("open");
    do_trial(4'b0101);
    do_trial(4'b0101);
    bus.try_code = 4'b0101;
    bus.try_valid = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    vec++;
    if (bus.alarm !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset_lockout: alarm=%b required 1", bus.alarm);
    end
    reset_pulse("lockout");
    do_trial(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_key(4'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        c = ($urandom_range(0, 2) == 0) ? m_key : 4'($urandom);
        do_trial(c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_fail_then_open();
    test_lockout();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end
endmodule
